tx_24bits: RTL and testbench



---
 rtl/tx_24bits.sv | 149 ++++++++++++++
 tb/tb_tx_24bits.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_24bits.sv
// tx_24bits: framed serial transmitter for the header-plus-three-byte link.
// Each accepted 20-bit payload is packed into three bytes with guard zeros.
// The packed bytes follow an 0xFF sync byte. All four bytes are sent as
// 8N1 UART, LSB first, using a built-in baud counter.
// Build option: define TX_DOUBLE_STOP_EN to end every byte with two stop bits.
module tx_24bits #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tx_start,
    input  logic [19:0] tx_data,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

`ifdef TX_DOUBLE_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic             stop_idx;
    logic [23:0]      word;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             stop_last;

    assign bit_end   = (baud_cnt == CNT_W'(CPB - 1));
    assign stop_last = (stop_idx == 1'(NSTOP - 1));

    // Guard zeros at W[16], W[12:11] and W[0] keep every payload byte below 0xFF
    function automatic logic [23:0] pack_word(input logic [19:0] d);
        return {d[19:13], 1'b0, d[12:10], 2'b00, d[9:0], 1'b0};
    endfunction

    // Payload byte that follows byte index idx (0 = sync byte just sent)
    function automatic logic [7:0] next_byte(input logic [23:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[23:16];
            2'd1:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    // Frame sequencer: sync byte plus three payload bytes, bit timing from baud_cnt
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            stop_idx <= 1'b0;
            word     <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (tx_start) begin
                        state    <= S_START;
                        word     <= pack_word(tx_data);
                        shreg    <= 8'hFF;
                        byte_idx <= '0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state    <= S_STOP;
                            stop_idx <= 1'b0;
                            tx       <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!stop_last) begin
                            stop_idx <= stop_idx + 1'b1;
                        end else if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 1'b1;
                            shreg    <= next_byte(word, byte_idx);
                            state    <= S_START;
                            tx       <= 1'b0;
                        end else begin
                            tx_done <= 1'b1;
                            // A held request restarts on the same edge so frames run back-to-back
                            if (tx_start) begin
                                state    <= S_START;
                                word     <= pack_word(tx_data);
                                shreg    <= 8'hFF;
                                byte_idx <= '0;
                                tx       <= 1'b0;
                            end else begin
                                state    <= S_IDLE;
                                byte_idx <= '0;
                                tx       <= 1'b1;
                                tx_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_24bits.sv
// tb_tx_24bits: scoreboard bench for tx_24bits (CPB = 10).
// The stimulus pushes the expected line bytes; a line monitor decodes UART bytes and pops them.
module tb_tx_24bits;

    localparam int CPB = 10;
`ifdef TX_DOUBLE_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int BPB = 9 + NSTOP;
    localparam int F   = 4 * BPB * CPB;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        tx_start = 1'b0;
    logic [19:0] tx_data = '0;
    logic        tx, tx_busy, tx_done;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int st_q[$];
    int done_cnt = 0;
    int ncyc = 0;

    always #5 CLK = ~CLK;

    tx_24bits #(.CLK_HZ(1000), .BAUD(100)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endfunction

    // Expected line bytes computed arithmetically from the payload fields
    function automatic void push_frame(input logic [19:0] d);
        int v, hi, mid, lo;
        v   = int'(d);
        hi  = (v / 8192) * 2;
        mid = ((v / 1024) % 8) * 32;
        lo  = (v % 1024) * 2;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'(hi));
        exp_q.push_back(8'(mid + lo / 256));
        exp_q.push_back(8'(lo % 256));
    endfunction

    // Line monitor: hunt for a start bit, sample every bit at its middle
    int mstate = 0;
    int pos = 0;
    int bi = 0;
    logic [7:0] sh = '0;
    logic [7:0] eb;
    always @(negedge CLK) begin
        ncyc++;
        if (tx_done === 1'b1) done_cnt++;
        if (RST) begin
            mstate = 0;
        end else if (mstate == 0) begin
            if (tx === 1'b0) begin
                mstate = 1;
                pos = 0;
                st_q.push_back(ncyc);
            end
        end else begin
            pos++;
            if (pos % CPB == CPB / 2) begin
                bi = pos / CPB;
                if (bi == 0) begin
                    check("start_bit", int'(tx), 0);
                end else if (bi <= 8) begin
                    sh[bi-1] = tx;
                end else begin
                    check("stop_bit", int'(tx), 1);
                    if (bi == 8 + NSTOP) begin
                        mstate = 0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", sh);
                        end else begin
                            eb = exp_q.pop_front();
                            check("line_byte", int'(sh), int'(eb));
                        end
                    end
                end
            end
        end
    end

    task automatic start_frame(input logic [19:0] d, input bit hold);
        push_frame(d);
        @(negedge CLK);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge CLK);
        if (!hold) begin
            tx_start = 1'b0;
            tx_data  = 20'($urandom);
        end
        check("accept_tx", int'(tx), 0);
        check("accept_busy", int'(tx_busy), 1);
    endtask

    task automatic wait_done(input int poke_at, input bit hold, output int n);
        n = 0;
        do begin
            tx_start = hold || (n == poke_at);
            if (n == poke_at) tx_data = 20'($urandom);
            @(negedge CLK);
            n++;
        end while (tx_done !== 1'b1 && n < F + 50);
        if (!hold) tx_start = 1'b0;
    endtask

    task automatic run_frame(input logic [19:0] d, input int poke_at);
        int n, d0;
        d0 = done_cnt;
        start_frame(d, 1'b0);
        wait_done(poke_at, 1'b0, n);
        check("done_latency", n, F);
        check("busy_at_done", int'(tx_busy), 0);
        @(negedge CLK);
        #1;
        check("done_pulse_width", int'(tx_done), 0);
        repeat (2 * CPB) @(negedge CLK);
        #1;
        check("done_count", done_cnt - d0, 1);
        check("idle_after_frame", int'(tx_busy), 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, d0;
        logic [19:0] hd;
        #2 RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        @(posedge CLK);
        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("post_rst_tx", int'(tx), 1);
        check("post_rst_busy", int'(tx_busy), 0);

        // Boundary payloads and a reference pattern
        run_frame(20'h00000, -1);
        run_frame(20'hFFFFF, -1);
        run_frame(20'hABCDE, -1);
        for (int i = 0; i < 3; i++) run_frame(20'($urandom), -1);

        // A second request mid-frame must be dropped
        run_frame(20'($urandom), 150);

        // Asynchronous reset while the third byte's start bit is on the line
        d0 = done_cnt;
        start_frame(20'($urandom), 1'b0);
        repeat (200) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(tx_busy), 0);
        exp_q.delete();
        @(posedge CLK);
        #2 RST = 1'b0;
        repeat (F + 20) @(negedge CLK);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_tx", int'(tx), 1);
        run_frame(20'h12345, -1);

        // Request held high: frames run back-to-back
        d0 = done_cnt;
        st_q.delete();
        hd = 20'($urandom);
        start_frame(hd, 1'b1);
        for (int i = 0; i < 3; i++) push_frame(hd);
        for (int i = 0; i < 3; i++) begin
            wait_done(-1, 1'b1, n);
            check("b2b_latency", n, F);
            check("b2b_busy", int'(tx_busy), 1);
        end
        tx_start = 1'b0;
        wait_done(-1, 1'b0, n);
        check("b2b_last_latency", n, F);
        check("b2b_last_busy", int'(tx_busy), 0);
        repeat (2 * CPB) @(negedge CLK);
        #1;
        check("b2b_done_count", done_cnt - d0, 4);
        check("b2b_queue_empty", exp_q.size(), 0);
        check("b2b_byte_count", st_q.size(), 16);
        for (int i = 1; i < st_q.size(); i++)
            check("b2b_byte_spacing", st_q[i] - st_q[i-1], BPB * CPB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
